// File: rtl/flag_ctrl.sv
`timescale 1ns/1ps
// flag_ctrl: sequences Z/C flag writes, branch-condition resolution and a LIFO of saved flags.
// Build option FLAG_CTRL_FWD_EN: accept BRANCH/PUSH during a pending write, using forwarded flags.
module flag_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_valid_i,
  input  logic [1:0] req_op_i,
  input  logic [2:0] req_cond_i,
  input  logic       z_alu_i,
  input  logic       c_alu_i,
  input  logic       z_cur_i,
  input  logic       c_cur_i,
  input  logic       err_clr_i,
  output logic       req_ready_o,
  output logic       flags_load_o,
  output logic       z_next_o,
  output logic       c_next_o,
  output logic       br_valid_o,
  output logic       br_taken_o,
  output logic       stk_full_o,
  output logic       stk_empty_o,
  output logic       stk_err_o
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;  // pointer spans 0..DEPTH
  localparam int unsigned AW = PW - 1;             // entry index width

  typedef enum logic [1:0] {
    OP_ALU_UPD = 2'b00,
    OP_BRANCH  = 2'b01,
    OP_PUSH    = 2'b10,
    OP_POP     = 2'b11
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_e;

  function automatic logic cond_eval(input logic [2:0] cond, input logic z, input logic c);
    logic hit;
    case (cond)
      3'b000:  hit = 1'b1;
      3'b001:  hit = z;
      3'b010:  hit = ~z;
      3'b011:  hit = c;
      3'b100:  hit = ~c;
      3'b101:  hit = z | c;
      3'b110:  hit = ~z & ~c;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [1:0]    stk_mem_q [DEPTH];
  logic          flags_load_q, flags_load_d;
  logic          z_next_q, z_next_d;
  logic          c_next_q, c_next_d;
  logic          br_valid_q, br_valid_d;
  logic          br_taken_q, br_taken_d;
  logic          stk_err_q, stk_err_d;

  op_e           op;
  logic          stall;
  logic          accept;
  logic          full;
  logic          empty;
  logic          z_src;
  logic          c_src;
  logic          do_push;
  logic          err_set;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;

  assign op      = op_e'(req_op_i);
  assign full    = (ptr_q == PW'(DEPTH));
  assign empty   = (ptr_q == '0);
  assign wr_idx  = ptr_q[AW-1:0];
  assign top_idx = ptr_q[AW-1:0] - AW'(1);

`ifdef FLAG_CTRL_FWD_EN
  // While a write is in flight the flags register still shows the old value,
  // so readers take the value being loaded this cycle instead.
  assign stall = 1'b0;
  assign z_src = (state_q == S_PEND) ? z_next_q : z_cur_i;
  assign c_src = (state_q == S_PEND) ? c_next_q : c_cur_i;
`else
  // Readers of the flags wait out the in-flight write for one cycle.
  assign stall = (state_q == S_PEND) && ((op == OP_BRANCH) || (op == OP_PUSH));
  assign z_src = z_cur_i;
  assign c_src = c_cur_i;
`endif

  assign req_ready_o = ~stall;
  assign accept      = req_valid_i & ~stall;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = S_IDLE;
    ptr_d        = ptr_q;
    flags_load_d = 1'b0;
    z_next_d     = z_next_q;
    c_next_d     = c_next_q;
    br_valid_d   = 1'b0;
    br_taken_d   = 1'b0;
    do_push      = 1'b0;
    err_set      = 1'b0;

    if (accept) begin
      unique case (op)
        OP_ALU_UPD: begin
          flags_load_d = 1'b1;
          z_next_d     = z_alu_i;
          c_next_d     = c_alu_i;
          state_d      = S_PEND;
        end
        OP_BRANCH: begin
          br_valid_d = 1'b1;
          br_taken_d = cond_eval(req_cond_i, z_src, c_src);
        end
        OP_PUSH: begin
          if (full) begin
            err_set = 1'b1;
          end else begin
            do_push = 1'b1;
            ptr_d   = ptr_q + PW'(1);
          end
        end
        OP_POP: begin
          if (empty) begin
            err_set = 1'b1;
          end else begin
            ptr_d                  = ptr_q - PW'(1);
            flags_load_d           = 1'b1;
            {z_next_d, c_next_d}   = stk_mem_q[top_idx];
            state_d                = S_PEND;
          end
        end
      endcase
    end

    // A new error in the same cycle as a clear keeps the flag set.
    stk_err_d = err_set | (stk_err_q & ~err_clr_i);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      flags_load_q <= 1'b0;
      z_next_q     <= 1'b0;
      c_next_q     <= 1'b0;
      br_valid_q   <= 1'b0;
      br_taken_q   <= 1'b0;
      stk_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      flags_load_q <= flags_load_d;
      z_next_q     <= z_next_d;
      c_next_q     <= c_next_d;
      br_valid_q   <= br_valid_d;
      br_taken_q   <= br_taken_d;
      stk_err_q    <= stk_err_d;
    end
  end

  // NOTE: the save stack has no reset; the pointer alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      stk_mem_q[wr_idx] <= {z_src, c_src};
    end
  end

  assign flags_load_o = flags_load_q;
  assign z_next_o     = z_next_q;
  assign c_next_o     = c_next_q;
  assign br_valid_o   = br_valid_q;
  assign br_taken_o   = br_taken_q;
  assign stk_full_o   = full;
  assign stk_empty_o  = empty;
  assign stk_err_o    = stk_err_q;

endmodule

// File: tb/tb_flag_ctrl.sv
`timescale 1ns/1ps
// tb_flag_ctrl: random and directed requests against a queue-based flag/stack model;
// a monitor pops expected loads and branch results and compares them cycle-exactly.
module tb_flag_ctrl;

  localparam int DEPTH = 4;
  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_BR   = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_POP  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_op = 2'b00;
  logic [2:0] req_cond = 3'b000;
  logic       z_alu = 1'b0;
  logic       c_alu = 1'b0;
  logic       err_clr = 1'b0;
  logic [1:0] flags_q;
  logic       req_ready, flags_load, z_next, c_next, br_valid, br_taken;
  logic       stk_full, stk_empty, stk_err;

  flag_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_op_i     (req_op),
    .req_cond_i   (req_cond),
    .z_alu_i      (z_alu),
    .c_alu_i      (c_alu),
    .z_cur_i      (flags_q[1]),
    .c_cur_i      (flags_q[0]),
    .err_clr_i    (err_clr),
    .req_ready_o  (req_ready),
    .flags_load_o (flags_load),
    .z_next_o     (z_next),
    .c_next_o     (c_next),
    .br_valid_o   (br_valid),
    .br_taken_o   (br_taken),
    .stk_full_o   (stk_full),
    .stk_empty_o  (stk_empty),
    .stk_err_o    (stk_err)
  );

  initial forever #5 clk = ~clk;

  // The flags register this block drives.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          flags_q <= 2'b00;
    else if (flags_load) flags_q <= {z_next, c_next};
  end

  typedef struct {
    int         due;
    logic [1:0] val;
  } exp_t;

  exp_t       q_load[$];
  exp_t       q_br[$];
  logic [1:0] model_stk[$];
  logic [1:0] arch = 2'b00;   // architectural {Z,C} after every accepted write
  bit         pend = 1'b0;    // a flag write was accepted on the previous edge
  bit         m_err = 1'b0;
  logic [1:0] hold = 2'b00;   // last {z_next,c_next} presented
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit taken(input logic [2:0] cond, input logic [1:0] f);
    bit z = f[1];
    bit c = f[0];
    case (cond)
      3'd0:    return 1'b1;
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return c;
      3'd4:    return !c;
      3'd5:    return z || c;
      3'd6:    return !z && !c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit model_ready(input logic [1:0] op);
`ifdef FLAG_CTRL_FWD_EN
    return 1'b1;
`else
    return !(pend && (op == OP_BR || op == OP_PUSH));
`endif
  endfunction

  task automatic model_reset();
    q_load.delete();
    q_br.delete();
    model_stk.delete();
    arch  = 2'b00;
    pend  = 1'b0;
    m_err = 1'b0;
    hold  = 2'b00;
  endtask

  // One clock of stimulus; returns whether the request was accepted.
  task automatic step(input bit v, input logic [1:0] op, input logic [2:0] cond,
                      input logic za, input logic ca, input logic clr, output bit acc);
    bit   rdy;
    bit   set;
    bit   nxt_pend;
    exp_t e;
    req_valid = v;
    req_op    = op;
    req_cond  = cond;
    z_alu     = za;
    c_alu     = ca;
    err_clr   = clr;
    rdy       = model_ready(op);
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(rdy));
    acc = v && rdy;
    @(posedge clk);
    #1;
    set      = 1'b0;
    nxt_pend = 1'b0;
    e.due    = cyc;
    if (acc) begin
      case (op)
        OP_ALU: begin
          e.val = {za, ca};
          q_load.push_back(e);
          arch     = {za, ca};
          nxt_pend = 1'b1;
        end
        OP_BR: begin
          e.val = {1'b0, taken(cond, arch)};
          q_br.push_back(e);
        end
        OP_PUSH: begin
          if (model_stk.size() < DEPTH) model_stk.push_back(arch);
          else set = 1'b1;
        end
        default: begin
          if (model_stk.size() > 0) begin
            e.val = model_stk.pop_back();
            q_load.push_back(e);
            arch     = e.val;
            nxt_pend = 1'b1;
          end else begin
            set = 1'b1;
          end
        end
      endcase
    end
    m_err = set || (m_err && !clr);
    pend  = nxt_pend;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, OP_ALU, 3'd0, 1'b0, 1'b0, 1'b0, acc);
  endtask

  // Holds a request until it is accepted, within a small cycle budget.
  task automatic do_req(input logic [1:0] op, input logic [2:0] cond, input logic za, input logic ca);
    bit acc = 1'b0;
    for (int i = 0; i < 4 && !acc; i++) step(1'b1, op, cond, za, ca, 1'b0, acc);
    check("accept_within_budget", 32'(acc), 32'd1);
  endtask

  // Monitor: pops the scoreboard whenever an output is due and checks status every cycle.
  initial begin
    exp_t e;
    bit   exp_ld;
    bit   exp_br;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_ld = (q_load.size() > 0) && (q_load[0].due == cyc);
        check("flags_load", 32'(flags_load), 32'(exp_ld));
        if (exp_ld) begin
          e = q_load.pop_front();
          check("flags_data", 32'({z_next, c_next}), 32'(e.val));
          hold = e.val;
        end else begin
          check("flags_hold", 32'({z_next, c_next}), 32'(hold));
        end
        exp_br = (q_br.size() > 0) && (q_br[0].due == cyc);
        check("br_valid", 32'(br_valid), 32'(exp_br));
        if (exp_br) begin
          e = q_br.pop_front();
          check("br_taken", 32'(br_taken), 32'(e.val[0]));
        end
        check("stk_full", 32'(stk_full), 32'(model_stk.size() == DEPTH));
        check("stk_empty", 32'(stk_empty), 32'(model_stk.size() == 0));
        check("stk_err", 32'(stk_err), 32'(m_err));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit               acc;
    logic [1:0]       pairs[4];
    logic [1:0]       pushv[4];
    logic [1:0]       op;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_flags_load", 32'(flags_load), 32'd0);
    check("rst_br_valid", 32'(br_valid), 32'd0);
    check("rst_stk_empty", 32'(stk_empty), 32'd1);
    check("rst_stk_full", 32'(stk_full), 32'd0);
    check("rst_stk_err", 32'(stk_err), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Reset in the middle of a flag write cancels it
    step(1'b1, OP_ALU, 3'd0, 1'b1, 1'b1, 1'b0, acc);
    check("load_before_rst", 32'(flags_load), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_load", 32'(flags_load), 32'd0);
    check("rst_mid_next", 32'({z_next, c_next}), 32'd0);
    check("rst_mid_br", 32'({br_valid, br_taken}), 32'd0);
    check("rst_mid_err", 32'(stk_err), 32'd0);
    check("rst_mid_empty", 32'(stk_empty), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);

    // ALU_UPD then BRANCH on Z
    step(1'b1, OP_ALU, 3'd0, 1'b1, 1'b0, 1'b0, acc);
    do_req(OP_BR, 3'd1, 1'b0, 1'b0);
    idle(2);

    // Condition sweep over all flag combinations
    pairs = '{2'b10, 2'b01, 2'b00, 2'b11};
    for (int p = 0; p < 4; p++) begin
      do_req(OP_ALU, 3'd0, pairs[p][1], pairs[p][0]);
      for (int c = 0; c < 8; c++) do_req(OP_BR, 3'(c), 1'b0, 1'b0);
    end
    idle(2);

    // Stack round trip with overflow
    pushv = '{2'b01, 2'b10, 2'b11, 2'b00};
    for (int p = 0; p < 4; p++) begin
      do_req(OP_ALU, 3'd0, pushv[p][1], pushv[p][0]);
      do_req(OP_PUSH, 3'd0, 1'b0, 1'b0);
    end
    idle(1);
    check("full_after_4", 32'(stk_full), 32'd1);
    do_req(OP_PUSH, 3'd0, 1'b0, 1'b0);
    check("overflow_err", 32'(stk_err), 32'd1);
    check("full_after_ovf", 32'(stk_full), 32'd1);
    for (int p = 0; p < 4; p++) do_req(OP_POP, 3'd0, 1'b0, 1'b0);
    idle(1);
    check("empty_after_pops", 32'(stk_empty), 32'd1);

    // Underflow, clear, and clear colliding with a new underflow
    step(1'b0, OP_ALU, 3'd0, 1'b0, 1'b0, 1'b1, acc);
    check("err_cleared_1", 32'(stk_err), 32'd0);
    do_req(OP_POP, 3'd0, 1'b0, 1'b0);
    check("underflow_err", 32'(stk_err), 32'd1);
    step(1'b0, OP_ALU, 3'd0, 1'b0, 1'b0, 1'b1, acc);
    check("err_cleared_2", 32'(stk_err), 32'd0);
    do_req(OP_POP, 3'd0, 1'b0, 1'b0);
    step(1'b1, OP_POP, 3'd0, 1'b0, 1'b0, 1'b1, acc);
    check("err_set_wins", 32'(stk_err), 32'd1);
    step(1'b0, OP_ALU, 3'd0, 1'b0, 1'b0, 1'b1, acc);
    idle(1);

    // Back-to-back flag writes
    do_req(OP_ALU, 3'd0, 1'b1, 1'b1);
    do_req(OP_PUSH, 3'd0, 1'b0, 1'b0);
    step(1'b1, OP_ALU, 3'd0, 1'b1, 1'b0, 1'b0, acc);
    check("b2b_accept_alu1", 32'(acc), 32'd1);
    step(1'b1, OP_POP, 3'd0, 1'b0, 1'b0, 1'b0, acc);
    check("b2b_accept_pop", 32'(acc), 32'd1);
    step(1'b1, OP_ALU, 3'd0, 1'b0, 1'b1, 1'b0, acc);
    check("b2b_accept_alu2", 32'(acc), 32'd1);
    idle(2);

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      op = 2'($urandom_range(3));
      step($urandom_range(9) < 8, op, 3'($urandom_range(7)),
           1'($urandom_range(1)), 1'($urandom_range(1)),
           $urandom_range(7) == 0, acc);
    end
    idle(3);

    check("load_queue_drained", 32'(q_load.size()), 32'd0);
    check("branch_queue_drained", 32'(q_br.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/flag_ctrl.md
Name: flag_ctrl

Overview:
- Sequencer for the Z/C flags register. All flag writes, flag-conditioned branch decisions and flag save/restore go through this block as a single request stream.
- Drives the flags register's load/data inputs and reads back its outputs.
- Resolves branch conditions and keeps a small LIFO of saved flags for CALL/RET and interrupt entry/exit.
- Sits between the instruction decoder/ALU and the flags register.

Parameters:
DEPTH, 4, number of entries in the flag save stack (power of two, 2..16)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_op  in  2  00 ALU_UPD, 01 BRANCH, 10 PUSH, 11 POP
req_cond  in  3  branch condition, used only for BRANCH
z_alu  in  1  zero flag from ALU, used only for ALU_UPD
c_alu  in  1  carry flag from ALU, used only for ALU_UPD
z_cur  in  1  current Z from flags register
c_cur  in  1  current C from flags register
err_clr  in  1  clears stk_err
req_ready  out  1  request accepted when req_valid & req_ready
flags_load  out  1  load strobe to flags register
z_next  out  1  Z data to flags register
c_next  out  1  C data to flags register
br_valid  out  1  branch result valid pulse
br_taken  out  1  branch decision, qualified by br_valid
stk_full  out  1  stack holds DEPTH entries
stk_empty  out  1  stack holds 0 entries
stk_err  out  1  sticky overflow/underflow error

Behaviour:
- Reset (rst=0, asynchronous): all of the following clear.
  - flags_load, z_next, c_next, br_valid, br_taken, stk_err = 0.
  - Stack pointer = 0, so stk_empty=1 and stk_full=0.
  - FSM goes to IDLE.
  - A pending flag write is cancelled; no load is issued after reset releases.
- Handshake: one request per cycle. An op is accepted on a clk edge where req_valid & req_ready. Inputs are sampled only on acceptance.
- Registered outputs: flags_load, z_next, c_next, br_valid and br_taken are registered. Each is valid for exactly one cycle (cycle N+1) following acceptance in cycle N. flags_load=0 otherwise; z_next/c_next hold their last values.
- ALU_UPD: in N+1, flags_load=1, z_next=z_alu, c_next=c_alu. The flags register updates at the end of N+1, so new flags are visible on z_cur/c_cur in N+2.
- POP:
  - Stack not empty: pointer decrements, and N+1 carries flags_load=1 with {z_next,c_next} = top entry.
  - Stack empty: no load, pointer unchanged, stk_err set.
- PUSH:
  - Stack not full: {z_cur,c_cur} written to entry[ptr], pointer increments. No load issued.
  - Stack full: push dropped, stk_err set.
- BRANCH: in N+1, br_valid=1 and br_taken = f(req_cond, z, c), using the z_cur/c_cur sampled at N.
  - Conditions: 000 always; 001 Z; 010 !Z; 011 C; 100 !C; 101 Z|C; 110 !Z&!C; 111 never.
- FSM:
  - IDLE: req_ready=1. Accepting ALU_UPD or a non-empty POP moves to PEND. Any other accept stays in IDLE.
  - PEND (a flag write is being issued this cycle):
    - ALU_UPD and POP are accepted, so back-to-back writes are allowed; accepting a write stays in PEND.
    - BRANCH and PUSH would read stale flags, so req_ready=0 for them: a stall of exactly 1 cycle.
    - With no write accepted, return to IDLE.
  - req_ready is combinational from state and req_op.
- Stack status: stk_full / stk_empty are decoded from the pointer (0..DEPTH) and update the cycle after the push/pop edge.
- stk_err:
  - Set by overflow or underflow; held until err_clr=1 or reset.
  - err_clr and a new error in the same cycle: set wins.
- Stack contents are not cleared by reset (don't-care); only the pointer resets.

Optional Feature:
FLAG_CTRL_FWD_EN
- Defined: in PEND, BRANCH and PUSH are also accepted with no stall. They use forwarded flags z_next/c_next (the value being loaded this cycle) instead of z_cur/c_cur.
- Undefined: the 1-cycle stall described above applies.
- Functional results are identical in both builds; only timing differs.

Test Plan:
1. Reset mid-write: accept ALU_UPD z_alu=1,c_alu=1, assert rst=0 in N+1 -> flags_load=0 immediately; all outputs 0, stk_empty=1; no load after release.
2. ALU_UPD then BRANCH: ALU_UPD z=1,c=0 accepted at N; BRANCH cond=001 presented at N+1.
   - No macro -> req_ready=0 at N+1; accepted N+2; br_valid=1, br_taken=1 at N+3.
   - FLAG_CTRL_FWD_EN -> accepted N+1; br_taken=1 at N+2.
3. Condition sweep: flags {Z,C}=10, 01, 00, 11 -> each cond 000..111 produces the decision-table result. Covers 32 BRANCH ops.
4. Stack round-trip, DEPTH=4: push flags 01,10,11,00 -> stk_full=1, 5th push -> stk_err=1, pointer stays 4. Then 4 POPs -> loads 00,11,10,01 in order, stk_empty=1.
5. Underflow: POP with empty stack -> no flags_load, stk_err=1. err_clr=1 -> stk_err=0. err_clr concurrent with another underflow -> stk_err stays 1.
6. Back-to-back writes: ALU_UPD (1,0), POP, ALU_UPD (0,1) on consecutive cycles -> flags_load=1 for 3 consecutive cycles with the correct data each, req_ready never drops.
